// File: rtl/jt7759_pkg.sv
// -----------------------------------------------------------------------------
// jt7759_pkg
// Tables and helpers shared by the jt7759 ADPCM decoder and the encoder, so
// both ends reconstruct samples from exactly the same data.
//   enc_state_t : encoder FSM states
//   STEP_MAG    : step magnitudes per ADPCM state, codes 0..7 (8..15 negate)
//   ADJ         : state adjustment per code
//   step_val()  : signed step for (state, code)
//   sat9()      : saturate a 10-bit sum to the signed 9-bit range
// -----------------------------------------------------------------------------
package jt7759_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_UPDATE,
        S_OUT
    } enc_state_t;

    // Codes 8..15 mirror 0..7 with the opposite sign, so only magnitudes
    // are stored. The largest magnitude (214) needs a 9-bit signed result.
    localparam logic [7:0] STEP_MAG [16][8] = '{
        '{8'd0, 8'd0,  8'd1,  8'd2,  8'd3,  8'd5,   8'd7,   8'd10 },
        '{8'd0, 8'd1,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd13 },
        '{8'd0, 8'd1,  8'd2,  8'd4,  8'd5,  8'd7,   8'd10,  8'd15 },
        '{8'd0, 8'd1,  8'd3,  8'd4,  8'd6,  8'd9,   8'd13,  8'd19 },
        '{8'd0, 8'd2,  8'd3,  8'd5,  8'd8,  8'd11,  8'd15,  8'd23 },
        '{8'd0, 8'd2,  8'd4,  8'd7,  8'd10, 8'd14,  8'd19,  8'd29 },
        '{8'd0, 8'd3,  8'd5,  8'd8,  8'd12, 8'd16,  8'd22,  8'd33 },
        '{8'd1, 8'd4,  8'd7,  8'd10, 8'd15, 8'd20,  8'd29,  8'd43 },
        '{8'd1, 8'd4,  8'd8,  8'd13, 8'd18, 8'd25,  8'd35,  8'd53 },
        '{8'd1, 8'd6,  8'd10, 8'd16, 8'd22, 8'd31,  8'd43,  8'd64 },
        '{8'd2, 8'd7,  8'd12, 8'd19, 8'd27, 8'd37,  8'd51,  8'd76 },
        '{8'd2, 8'd9,  8'd16, 8'd24, 8'd34, 8'd46,  8'd64,  8'd96 },
        '{8'd3, 8'd11, 8'd19, 8'd29, 8'd41, 8'd57,  8'd79,  8'd117},
        '{8'd4, 8'd13, 8'd24, 8'd36, 8'd50, 8'd69,  8'd96,  8'd143},
        '{8'd4, 8'd16, 8'd29, 8'd44, 8'd62, 8'd85,  8'd118, 8'd175},
        '{8'd6, 8'd20, 8'd36, 8'd54, 8'd76, 8'd104, 8'd144, 8'd214}
    };

    localparam logic signed [2:0] ADJ [16] = '{
        -3'sd1, -3'sd1, 3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd3,
        -3'sd1, -3'sd1, 3'sd0, 3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd3
    };

    function automatic logic signed [8:0] step_val(input logic [3:0] st,
                                                   input logic [3:0] n);
        logic signed [8:0] smag;
        smag = $signed({1'b0, STEP_MAG[st][n[2:0]]});
        return n[3] ? -smag : smag;
    endfunction

    function automatic logic signed [8:0] sat9(input logic signed [9:0] s);
        if (s > 10'sd255)
            return 9'sd255;
        else if (s < -10'sd256)
            return $signed(9'h100);
        return s[8:0];
    endfunction

endpackage

// File: rtl/jt7759_enc_if.sv
// -----------------------------------------------------------------------------
// jt7759_enc_if
// Sample-in / nibble-out handshake bundle of the jt7759 encoder.
//   pcm, pcm_valid, pcm_ready : signed 9-bit sample input, valid/ready
//   nibble, nib_valid, nib_ready : 4-bit code output, valid/ready
//   pred : reconstructed sample after the emitted nibble
// slave = encoder side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface jt7759_enc_if;
    logic signed [8:0] pcm;
    logic              pcm_valid;
    logic              pcm_ready;
    logic        [3:0] nibble;
    logic              nib_valid;
    logic              nib_ready;
    logic signed [8:0] pred;

    modport master (
        output pcm, pcm_valid, nib_ready,
        input  pcm_ready, nibble, nib_valid, pred
    );

    modport slave (
        input  pcm, pcm_valid, nib_ready,
        output pcm_ready, nibble, nib_valid, pred
    );
endinterface

// File: rtl/jt7759_enc_model.sv
// -----------------------------------------------------------------------------
// jt7759_enc_model
// Combinational copy of the jt7759 decoder reconstruction step.
//   i_acc      : current signed 9-bit predictor
//   i_st       : current ADPCM state 0..15
//   i_n        : code to apply
//   o_acc_next : saturated predictor after the code
//   o_st_next  : state after the code, clamped to 0..15
// -----------------------------------------------------------------------------
module jt7759_enc_model
    import jt7759_pkg::*;
(
    input  logic signed [8:0] i_acc,
    input  logic        [3:0] i_st,
    input  logic        [3:0] i_n,
    output logic signed [8:0] o_acc_next,
    output logic        [3:0] o_st_next
);

    logic signed [8:0] w_step;
    logic signed [9:0] w_sum;
    logic        [5:0] w_st_sum;

    assign w_step     = step_val(i_st, i_n);
    assign w_sum      = {i_acc[8], i_acc} + {w_step[8], w_step};
    assign o_acc_next = sat9(w_sum);

    // State sum spans -1..18; bit 5 flags negative, bit 4 flags above 15.
    assign w_st_sum = {2'b00, i_st} + {{3{ADJ[i_n][2]}}, ADJ[i_n]};

    always_comb begin
        o_st_next = w_st_sum[3:0];
        if (w_st_sum[5])
            o_st_next = 4'd0;
        else if (w_st_sum[4])
            o_st_next = 4'd15;
    end

endmodule

// File: rtl/jt7759_enc.sv
// -----------------------------------------------------------------------------
// jt7759_enc
// ADPCM encoder producing the nibble stream for the jt7759 decoder. Each
// sample is encoded by trying all 16 codes against the decoder model, one per
// enabled cycle, and committing the code with the smallest error.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   cen  : clock enable, all state advances only when high
//   clr  : synchronous model reset (honoured when cen=1)
//   io   : sample/nibble handshake bundle (slave side)
// -----------------------------------------------------------------------------
module jt7759_enc
    import jt7759_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic cen,
    input  logic clr,
    jt7759_enc_if.slave io
);

    enc_state_t        r_state;
    enc_state_t        w_next_state;
    logic signed [8:0] r_tgt;
    logic signed [8:0] r_acc;
    logic        [3:0] r_st;
    logic        [3:0] r_k;
    logic        [3:0] r_best_k;
    logic        [9:0] r_best_err;
    logic        [3:0] r_nibble;
    logic signed [8:0] r_pred;
    logic              r_nib_valid;

    logic        [3:0] w_n;
    logic signed [8:0] w_acc_next;
    logic        [3:0] w_st_next;
    logic        [9:0] w_diff;
    logic        [9:0] w_err;

    // The single model instance scores candidate r_k while searching and
    // replays the winning code in UPDATE.
    assign w_n = (r_state == S_UPDATE) ? r_best_k : r_k;

    jt7759_enc_model u_model (
        .i_acc      (r_acc),
        .i_st       (r_st),
        .i_n        (w_n),
        .o_acc_next (w_acc_next),
        .o_st_next  (w_st_next)
    );

    assign w_diff = {r_tgt[8], r_tgt} - {w_acc_next[8], w_acc_next};
    assign w_err  = w_diff[9] ? (10'd0 - w_diff) : w_diff;

    assign io.pcm_ready = (r_state == S_IDLE);
    assign io.nibble    = r_nibble;
    assign io.pred      = r_pred;
    assign io.nib_valid = r_nib_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (io.pcm_valid) w_next_state = S_SEARCH;
            S_SEARCH: if (r_k == 4'd15) w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = S_OUT;
            S_OUT:    if (io.nib_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        if (clr)
            w_next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= S_IDLE;
        else if (cen)
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tgt       <= '0;
            r_acc       <= '0;
            r_st        <= '0;
            r_k         <= '0;
            r_best_k    <= '0;
            r_best_err  <= '0;
            r_nibble    <= '0;
            r_pred      <= '0;
            r_nib_valid <= 1'b0;
        end else if (cen) begin
            if (clr) begin
                r_acc       <= '0;
                r_st        <= '0;
                r_k         <= '0;
                r_nibble    <= '0;
                r_pred      <= '0;
                r_nib_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (io.pcm_valid) begin
                            r_tgt <= io.pcm;
                            r_k   <= 4'd0;
                        end
                    end
                    S_SEARCH: begin
                        // Strict less-than keeps the lowest code on ties;
                        // k=0 always seeds the tracker.
                        if (r_k == 4'd0 || w_err < r_best_err) begin
                            r_best_k   <= r_k;
                            r_best_err <= w_err;
                        end
                        r_k <= r_k + 4'd1;
                    end
                    S_UPDATE: begin
                        r_acc       <= w_acc_next;
                        r_st        <= w_st_next;
                        r_nibble    <= r_best_k;
                        r_pred      <= w_acc_next;
                        r_nib_valid <= 1'b1;
                    end
                    S_OUT: begin
                        if (io.nib_ready)
                            r_nib_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt7759_enc.sv
// -----------------------------------------------------------------------------
// tb_jt7759_enc
// Self-checking bench for jt7759_enc. A reference encoder keeps its own copy
// of the decoder tables and predicts handshake, latency, nibble and pred on
// every cycle; directed samples with hand-worked results pin that reference.
// -----------------------------------------------------------------------------
module tb_jt7759_enc;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic cen  = 1'b1;
    logic clr  = 1'b0;

    jt7759_enc_if io();

    jt7759_enc dut (
        .clk  (clk),
        .rstn (rstn),
        .cen  (cen),
        .clr  (clr),
        .io   (io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cenQuarter = 1'b0;
    bit done = 1'b0;

    // Reference encoder state
    int mAcc = 0;
    int mSt = 0;
    int expNib = 0;
    int expPred = 0;
    int cntSince = 0;
    bit busy = 1'b0;

    int magTab [16][8] = '{
        '{0, 0, 1, 2, 3, 5, 7, 10},       '{0, 1, 2, 3, 4, 6, 8, 13},
        '{0, 1, 2, 4, 5, 7, 10, 15},      '{0, 1, 3, 4, 6, 9, 13, 19},
        '{0, 2, 3, 5, 8, 11, 15, 23},     '{0, 2, 4, 7, 10, 14, 19, 29},
        '{0, 3, 5, 8, 12, 16, 22, 33},    '{1, 4, 7, 10, 15, 20, 29, 43},
        '{1, 4, 8, 13, 18, 25, 35, 53},   '{1, 6, 10, 16, 22, 31, 43, 64},
        '{2, 7, 12, 19, 27, 37, 51, 76},  '{2, 9, 16, 24, 34, 46, 64, 96},
        '{3, 11, 19, 29, 41, 57, 79, 117},'{4, 13, 24, 36, 50, 69, 96, 143},
        '{4, 16, 29, 44, 62, 85, 118, 175},'{6, 20, 36, 54, 76, 104, 144, 214}
    };
    int adjTab [8] = '{-1, -1, 0, 0, 1, 2, 2, 3};

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Exhaustive best-code choice on plain integers.
    task automatic encodeModel(input int tgt);
        int cand, e, bestErr;
        bestErr = 100000;
        for (int k = 0; k < 16; k++) begin
            cand = mAcc + ((k >= 8) ? -magTab[mSt][k - 8] : magTab[mSt][k]);
            if (cand > 255) cand = 255;
            if (cand < -256) cand = -256;
            e = (tgt > cand) ? tgt - cand : cand - tgt;
            if (e < bestErr) begin
                bestErr = e;
                expNib  = k;
                expPred = cand;
            end
        end
        mAcc = expPred;
        mSt  = mSt + adjTab[expNib % 8];
        if (mSt < 0) mSt = 0;
        if (mSt > 15) mSt = 15;
    endtask

    // Every falling edge: check outputs, then predict the coming rising edge
    // from the inputs that are stable until it.
    task automatic monitorLoop();
        while (!done) begin
            @(negedge clk);
            checkOutput("pcm_ready", int'(io.pcm_ready), int'(!busy));
            checkOutput("nib_valid", int'(io.nib_valid), int'(busy && cntSince == 17));
            if (busy && cntSince == 17) begin
                checkOutput("nibble", int'(io.nibble), expNib);
                checkOutput("pred", int'(io.pred), expPred);
            end
            if (cen) begin
                if (clr) begin
                    mAcc = 0; mSt = 0; busy = 1'b0; cntSince = 0;
                end else if (busy && cntSince == 17) begin
                    if (io.nib_ready) busy = 1'b0;
                end else if (busy) begin
                    cntSince++;
                end else if (io.pcm_valid) begin
                    encodeModel(int'(io.pcm));
                    busy = 1'b1;
                    cntSince = 0;
                end
            end
        end
    endtask

    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            cnt++;
            cen = cenQuarter ? ((cnt % 4) == 0) : 1'b1;
        end
    end

    task automatic startSample(input int sample);
        bit taken = 1'b0;
        int guard = 0;
        io.pcm = 9'(sample);
        io.pcm_valid = 1'b1;
        while (!taken && guard < 500) begin
            @(negedge clk);
            taken = cen && io.pcm_ready;
            @(posedge clk); #1;
            guard++;
        end
        io.pcm_valid = 1'b0;
        checkOutput("accept_timeout", int'(taken), 1);
    endtask

    task automatic applyStimulus(input int sample, output int gotNib, output int gotPred);
        int guard = 0;
        startSample(sample);
        while (!io.nib_valid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("nib_timeout", int'(io.nib_valid), 1);
        gotNib  = int'(io.nibble);
        gotPred = int'(io.pred);
        @(posedge clk); #1;
    endtask

    task automatic doClr();
        bit hit = 1'b0;
        int guard = 0;
        clr = 1'b1;
        while (!hit && guard < 100) begin
            @(negedge clk);
            hit = cen;
            @(posedge clk); #1;
            guard++;
        end
        clr = 1'b0;
    endtask

    task automatic mainSequence();
        int n, p, g, edges;
        // Reset state, zero target: clamped state stays 0
        applyStimulus(0, n, p);
        checkOutput("zero_nibble", n, 0);
        checkOutput("zero_pred", p, 0);

        // Largest row-0 step, then row 3 proves the state moved to 3
        doClr();
        applyStimulus(10, n, p);
        checkOutput("step_nibble", n, 7);
        checkOutput("step_pred", p, 10);
        applyStimulus(29, n, p);
        checkOutput("row3_nibble", n, 7);
        checkOutput("row3_pred", p, 29);

        // -3 and -5 tie at error 1: lower code 12 wins
        doClr();
        applyStimulus(-4, n, p);
        checkOutput("neg_nibble", n, 12);
        checkOutput("neg_pred", p, -3);

        // Codes 0,1,8,9 all reach 0: code 0 wins
        doClr();
        applyStimulus(0, n, p);
        checkOutput("tie_nibble", n, 0);

        // Saturation at both rails
        doClr();
        for (int i = 0; i < 60; i++) applyStimulus(255, n, p);
        checkOutput("sat_hi_pred", p, 255);
        for (int i = 0; i < 60; i++) applyStimulus(-256, n, p);
        checkOutput("sat_lo_pred", p, -256);

        // Backpressure with ignored sample pulses
        doClr();
        io.nib_ready = 1'b0;
        applyStimulus(10, n, p);
        checkOutput("bp_nibble", n, 7);
        checkOutput("bp_pred", p, 10);
        for (int i = 0; i < 10; i++) begin
            io.pcm = 9'sd77;
            io.pcm_valid = i[0];
            @(posedge clk); #1;
        end
        io.pcm_valid = 1'b0;
        io.nib_ready = 1'b1;
        g = 0;
        while (io.nib_valid && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        applyStimulus(10, n, p);
        checkOutput("bp_next_nibble", n, 0);
        checkOutput("bp_next_pred", p, 10);

        // Quarter-rate clock enable gives the same codes
        doClr();
        cenQuarter = 1'b1;
        applyStimulus(10, n, p);
        checkOutput("qrate_nibble0", n, 7);
        checkOutput("qrate_pred0", p, 10);
        applyStimulus(29, n, p);
        checkOutput("qrate_nibble1", n, 7);
        checkOutput("qrate_pred1", p, 29);
        applyStimulus(-100, n, p);
        applyStimulus(55, n, p);
        cenQuarter = 1'b0;

        // clr while candidate k=6 is being scored
        doClr();
        applyStimulus(100, n, p);
        startSample(50);
        edges = 0;
        while (edges < 6) begin
            @(negedge clk);
            if (cen) edges++;
            @(posedge clk); #1;
        end
        doClr();
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(10, n, p);
        checkOutput("clr_nibble", n, 7);
        checkOutput("clr_pred", p, 10);

        // Long sine stream, checked cycle by cycle against the reference
        doClr();
        for (int i = 0; i < 1000; i++)
            applyStimulus($rtoi(200.0 * $sin(6.283185307 * i / 64.0)), n, p);
    endtask

    initial begin
        io.pcm = '0;
        io.pcm_valid = 1'b0;
        io.nib_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pcm_ready", int'(io.pcm_ready), 1);
        checkOutput("rst_nib_valid", int'(io.nib_valid), 0);
        checkOutput("rst_nibble", int'(io.nibble), 0);
        checkOutput("rst_pred", int'(io.pred), 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        fork
            monitorLoop();
            begin
                mainSequence();
                done = 1'b1;
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
